// File: rtl/uart_mem_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mem_dump_pkg
//  Description : Shared RIB bus types and constants used by the memory dump path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_mem_dump_pkg;

    typedef logic [31:0] MemAddrBus;
    typedef logic [31:0] MemBus;

    localparam MemBus ZeroWord     = 32'h0000_0000;
    localparam logic  WriteDisable = 1'b0;
    localparam logic  RstEnable    = 1'b1;
    localparam logic  RIB_REQ      = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_mem_dump_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 byte serialiser with back-to-back frame support.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import uart_mem_dump_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_start = 2'd1;
    localparam logic [1:0]  c_st_data  = 2'd2;
    localparam logic [1:0]  c_st_stop  = 2'd3;
    localparam logic [15:0] c_baud_last = 16'(CLK_DIV - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        w_baud_end;
    logic        w_load;

    assign w_baud_end = (r_baud == c_baud_last);
    // Ready in the final stop-bit cycle so the next start bit follows with no gap.
    assign ready_o    = (r_state == c_st_idle) || ((r_state == c_st_stop) && w_baud_end);
    assign w_load     = valid_i && ready_o;
    assign tx_o       = r_tx;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = c_st_start;
        end else begin
            case (r_state)
                c_st_start: if (w_baud_end) w_state_nxt = c_st_data;
                c_st_data:  if (w_baud_end && (r_bit == 3'd7)) w_state_nxt = c_st_stop;
                c_st_stop:  if (w_baud_end) w_state_nxt = c_st_idle;
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else if (w_load) begin
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= data_i;
            r_tx    <= 1'b0;
        end else begin
            case (r_state)
                c_st_start: begin
                    if (w_baud_end) begin
                        r_baud  <= 16'd0;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                c_st_data: begin
                    if (w_baud_end) begin
                        r_baud <= 16'd0;
                        if (r_bit == 3'd7) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                c_st_stop: begin
                    if (w_baud_end) begin
                        r_baud <= 16'd0;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: r_baud <= 16'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_mem_dump.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mem_dump
//  Description : RIB master that reads a block of words and streams them out
//                of a UART TX pin, little-endian byte order, 8N1.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_dump
    import uart_mem_dump_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,
    output logic             tx_pin
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_send  = 2'd2;
    localparam logic [1:0] c_st_next  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    MemAddrBus        r_addr;
    MemBus            r_word;
    logic [LEN_W-1:0] r_remaining;
    logic [1:0]       r_byte_idx;
    logic             r_done;
    logic             w_start_ok;
    logic             w_last_byte;
    logic             w_tx_valid;
    logic [7:0]       w_tx_data;
    logic             w_tx_ready;

    assign w_start_ok  = start_i && (r_state == c_st_idle);
    assign w_last_byte = (r_byte_idx == 2'd3);

    assign busy_o      = (r_state != c_st_idle);
    assign done_o      = r_done;
    assign req_o       = (r_state == c_st_fetch) ? RIB_REQ : ~RIB_REQ;
    assign mem_we_o    = WriteDisable;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = ZeroWord;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Byte 0 is forwarded straight from the bus so its start bit begins right after FETCH.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_valid  = 1'b0;
        w_tx_data   = r_word[{r_byte_idx + 2'd1, 3'b000} +: 8];
        case (r_state)
            c_st_idle: begin
                if (w_start_ok && (len_i != '0)) w_state_nxt = c_st_fetch;
            end
            c_st_fetch: begin
                w_tx_valid  = 1'b1;
                w_tx_data   = mem_rdata_i[7:0];
                w_state_nxt = c_st_send;
            end
            c_st_send: begin
                if (w_tx_ready) begin
                    if (w_last_byte) begin
                        w_state_nxt = c_st_next;
                    end else begin
                        w_tx_valid = 1'b1;
                    end
                end
            end
            c_st_next: begin
                w_state_nxt = (r_remaining == LEN_W'(1)) ? c_st_idle : c_st_fetch;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_addr      <= '0;
            r_word      <= '0;
            r_remaining <= '0;
            r_byte_idx  <= 2'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_start_ok) begin
                        if (len_i != '0) begin
                            r_addr      <= addr_i & 32'hFFFF_FFFC;
                            r_remaining <= len_i;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_st_fetch: begin
                    r_word     <= mem_rdata_i;
                    r_byte_idx <= 2'd0;
                end
                c_st_send: begin
                    if (w_tx_ready) begin
                        if (!w_last_byte) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end else if (r_remaining == LEN_W'(1)) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_st_next: begin
                    r_remaining <= r_remaining - LEN_W'(1);
                    r_addr      <= r_addr + 32'd4;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .valid_i (w_tx_valid),
        .data_i  (w_tx_data),
        .ready_o (w_tx_ready),
        .tx_o    (tx_pin)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_dump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_mem_dump
//  Description : Self-checking bench: per-cycle expectation queue built from
//                the dump rules, plus literal checks on decoded frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mem_dump;

    localparam int CLK_DIV  = 4;
    localparam int LEN_W    = 16;
    localparam int FRAME    = 10 * CLK_DIV;
    localparam int WORD_CYC = 2 + 4 * FRAME;
    localparam int LOG_N    = 2048;

    typedef struct packed {
        logic        tx;
        logic        req;
        logic        busy;
        logic        done;
        logic [31:0] addr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [31:0]      addr_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic             busy_o, done_o, req_o, mem_we_o, tx_pin;
    logic [31:0]      mem_addr_o, mem_wdata_o;
    logic [31:0]      mem_rdata_i = '0;

    int   tests = 0;
    int   fails = 0;
    int   k = 0;
    exp_t q[$];

    logic        log_tx[LOG_N];
    logic        log_req[LOG_N];
    logic        log_busy[LOG_N];
    logic        log_done[LOG_N];
    logic [31:0] log_addr[LOG_N];

    uart_mem_dump #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .addr_i      (addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .req_o       (req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .tx_pin      (tx_pin)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h4433_2211;
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    // Real data only while requested; noise otherwise so stray sampling shows up.
    always @(negedge clk) begin
        if (req_o === 1'b1) mem_rdata_i = mem_fn(mem_addr_o);
        else                mem_rdata_i = $urandom;
    end

    function automatic exp_t mk(input logic tx, input logic req, input logic busy,
                                input logic done, input logic [31:0] addr);
        exp_t e;
        e.tx = tx; e.req = req; e.busy = busy; e.done = done; e.addr = addr;
        return e;
    endfunction

    task automatic push_job(input logic [31:0] a, input logic [LEN_W-1:0] l);
        logic [31:0] aw, d;
        logic [7:0]  byt;
        logic        v;
        if (l == 0) begin
            q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0));
            return;
        end
        for (int w = 0; w < int'(l); w++) begin
            aw = {a[31:2], 2'b00} + 32'(4 * w);
            q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, aw));
            d = mem_fn(aw);
            for (int b = 0; b < 4; b++) begin
                byt = 8'(d >> (8 * b));
                for (int bi = 0; bi < 10; bi++) begin
                    if (bi == 0)      v = 1'b0;
                    else if (bi == 9) v = 1'b1;
                    else              v = byt[bi-1];
                    repeat (CLK_DIV) q.push_back(mk(v, 1'b0, 1'b1, 1'b0, aw));
                end
            end
            q.push_back(mk(1'b1, 1'b0, 1'b1, (w == int'(l) - 1), aw));
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // One clock: compare this cycle's outputs, then drive the next cycle's inputs.
    task automatic cycle(input logic st, input logic [31:0] a, input logic [LEN_W-1:0] l,
                         input logic r);
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) e = q.pop_front();
        else              e = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tests++;
        if (tx_pin !== e.tx || req_o !== e.req || busy_o !== e.busy || done_o !== e.done ||
            mem_we_o !== 1'b0 || mem_wdata_o !== 32'h0 ||
            (e.req && mem_addr_o !== e.addr)) begin
            fails++;
            $display("FAIL cycle t=%0t k=%0d: tx/req/busy/done/addr got %b%b%b%b %h expected %b%b%b%b %h",
                     $time, k, tx_pin, req_o, busy_o, done_o, mem_addr_o,
                     e.tx, e.req, e.busy, e.done, e.addr);
        end
        k++;
        if (k < LOG_N) begin
            log_tx[k] = tx_pin; log_req[k] = req_o; log_busy[k] = busy_o;
            log_done[k] = done_o; log_addr[k] = mem_addr_o;
        end
        start_i = st; addr_i = a; len_i = l; rst = r;
        if (r) begin
            q.delete();
        end else if (st && !e.busy) begin
            k = 0;
            for (int i = 0; i < LOG_N; i++) begin
                log_tx[i] = 1'b1; log_req[i] = 1'b0; log_busy[i] = 1'b0;
                log_done[i] = 1'b0; log_addr[i] = '0;
            end
            push_job(a, l);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 20000) begin
            cycle(1'b0, 32'h0, '0, 1'b0);
            guard++;
        end
        repeat (3) cycle(1'b0, 32'h0, '0, 1'b0);
    endtask

    function automatic logic [7:0] dec(input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = log_tx[2 + FRAME * b + CLK_DIV * (1 + i)];
        return v;
    endfunction

    function automatic int first_done();
        for (int i = 1; i < LOG_N; i++) if (log_done[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_done();
        int n = 0;
        for (int i = 1; i < LOG_N; i++) if (log_done[i] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        logic [31:0] ra;
        logic [LEN_W-1:0] rl;
        int g;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        lit("reset busy_o", 32'(busy_o), 32'h0);
        lit("reset done_o", 32'(done_o), 32'h0);
        lit("reset req_o", 32'(req_o), 32'h0);
        lit("reset mem_addr_o", mem_addr_o, 32'h0);
        lit("reset tx_pin", 32'(tx_pin), 32'h1);
        rst = 1'b0;

        // Single word
        cycle(1'b1, 32'h0000_0100, 16'd1, 1'b0);
        drain();
        lit("single req cycle", 32'(log_req[1]), 32'h1);
        lit("single req addr", log_addr[1], 32'h0000_0100);
        lit("single start bit", 32'(log_tx[2]), 32'h0);
        lit("single byte0", 32'(dec(0)), 32'h11);
        lit("single byte1", 32'(dec(1)), 32'h22);
        lit("single byte2", 32'(dec(2)), 32'h33);
        lit("single byte3", 32'(dec(3)), 32'h44);
        lit("single done latency", 32'(first_done()), 32'd162);

        // Multi-word, unaligned start address
        cycle(1'b1, 32'h0000_0203, 16'd3, 1'b0);
        drain();
        lit("multi addr0", log_addr[1], 32'h0000_0200);
        lit("multi addr1", log_addr[1 + WORD_CYC], 32'h0000_0204);
        lit("multi addr2", log_addr[1 + 2 * WORD_CYC], 32'h0000_0208);
        lit("multi done count", 32'(count_done()), 32'd1);
        lit("multi done latency", 32'(first_done()), 32'd486);

        // Zero length
        cycle(1'b1, 32'h0000_0500, 16'd0, 1'b0);
        drain();
        lit("zero done next", 32'(log_done[1]), 32'h1);
        lit("zero busy", 32'(log_busy[1]), 32'h0);
        lit("zero done count", 32'(count_done()), 32'd1);

        // Address wrap
        cycle(1'b1, 32'hFFFF_FFFC, 16'd2, 1'b0);
        drain();
        lit("wrap addr0", log_addr[1], 32'hFFFF_FFFC);
        lit("wrap addr1", log_addr[1 + WORD_CYC], 32'h0000_0000);

        // Start while busy is ignored
        cycle(1'b1, 32'h0000_0100, 16'd1, 1'b0);
        repeat (50) cycle(1'b0, 32'h0, '0, 1'b0);
        cycle(1'b1, 32'h0000_0300, 16'd3, 1'b0);
        drain();
        lit("busy-start done latency", 32'(first_done()), 32'd162);
        lit("busy-start word", {dec(3), dec(2), dec(1), dec(0)}, 32'h4433_2211);

        // Reset during a data bit of byte 2
        cycle(1'b1, 32'h0000_0100, 16'd1, 1'b0);
        repeat (2 + 2 * FRAME + 3 * CLK_DIV - 1) cycle(1'b0, 32'h0, '0, 1'b0);
        cycle(1'b0, 32'h0, '0, 1'b1);
        cycle(1'b0, 32'h0, '0, 1'b0);
        lit("rst-mid tx_pin", 32'(tx_pin), 32'h1);
        lit("rst-mid busy_o", 32'(busy_o), 32'h0);
        lit("rst-mid req_o", 32'(req_o), 32'h0);
        cycle(1'b1, 32'h0000_0100, 16'd1, 1'b0);
        drain();
        lit("post-reset word", {dec(3), dec(2), dec(1), dec(0)}, 32'h4433_2211);

        // Randomized jobs with stray starts and occasional resets
        for (int j = 0; j < 20; j++) begin
            ra = $urandom;
            rl = LEN_W'($urandom_range(0, 4));
            cycle(1'b1, ra, rl, 1'b0);
            g = 0;
            while (q.size() > 0 && g < 5000) begin
                cycle(($urandom_range(0, 39) == 0), $urandom,
                      LEN_W'($urandom_range(0, 7)), ($urandom_range(0, 299) == 0));
                g++;
            end
            repeat (3) cycle(1'b0, 32'h0, '0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
